exam_grade_sequencer: RTL and testbench
=======================================

EXAM_GRADE_SEQUENCER -- requirements
Module: exam_grade_sequencer

Interface
REQ-001 Parameter PASS_THRESH, default 100, minimum total for pass.
REQ-002 Parameter AWARD_THRESH, default 200, minimum total for scholarship; PASS_THRESH <= AWARD_THRESH.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 grade_valid  input  1  grade_data valid this cycle.
REQ-006 grade_data  input  8  one section grade, unsigned 0..255.
REQ-007 grade_ready  output  1  sequencer accepts a grade this cycle.
REQ-008 abort  input  1  discard the student in progress.
REQ-009 result_valid  output  1  result fields valid.
REQ-010 result_ready  input  1  consumer takes the result.
REQ-011 total  output  10  sum of the four sections, unsigned 0..1020.
REQ-012 failed / passed / award_scholarship  output  1 each  classification of total.
REQ-013 student_count / pass_count / award_count  output  8 each  completed-student statistics.

Function
REQ-014 Two states: COLLECT (grade_ready=1, result_valid=0) and RESULT (grade_ready=0, result_valid=1).
REQ-015 A grade is accepted on a cycle when grade_valid and grade_ready are both high.
REQ-016 Each accepted grade is added to a 10-bit accumulator, and a 2-bit section index increments.
REQ-017 The accumulator never overflows (4*255=1020 < 1024), so no saturation logic.
REQ-018 Acceptance of the 4th grade (index 3) in cycle N moves to RESULT.
REQ-019 In cycle N+1, result_valid=1 and total equals the full four-grade sum.
REQ-020 Classification: failed=(total<PASS_THRESH), passed=(total>=PASS_THRESH), award_scholarship=(total>=AWARD_THRESH).
REQ-021 At most one of failed/passed is high; award_scholarship implies passed.
REQ-022 In RESULT, all result outputs hold stable until the cycle with result_ready=1.
REQ-023 On that result_ready cycle: return to COLLECT, clear accumulator and index, and update counters.
REQ-024 The earliest next grade acceptance is the cycle after the result handshake, so there is no RESULT-to-COLLECT bypass.
REQ-025 Counters update once per completed result handshake: student_count+1, pass_count+1 if passed, award_count+1 if award_scholarship.
REQ-026 Counters wrap modulo 256.
REQ-027 abort in COLLECT clears accumulator and index in the same edge, and counters are unchanged.
REQ-028 abort has priority over a simultaneous grade acceptance; that grade is dropped.
REQ-029 abort in RESULT is ignored; the result must still be handshaken.
REQ-030 grade_valid during RESULT has no effect (grade_ready=0).
REQ-031 total, failed, passed and award_scholarship are registered outputs, not combinational from grade_data.
REQ-032 In COLLECT, total shows the running partial sum and the classification bits read 0.

Reset
REQ-033 rst=1 at a clock edge forces state COLLECT, accumulator=0, index=0 and all counters=0.
REQ-034 Outputs after reset: grade_ready=1, result_valid=0, total=0, failed=0, passed=0, award_scholarship=0.
REQ-035 rst takes priority over abort, handshakes and the RESULT hold; a student in progress or a pending result is discarded.

Structure
REQ-036 Shared package exam_pkg holds: state enum {COLLECT, RESULT}, GRADE_W=8, TOTAL_W=10, CNT_W=8, NUM_SECTIONS=4, and default thresholds 100/200.
REQ-037 One sub-module, grade_classifier, is purely combinational: total in, failed/passed/award out, parameterized by the thresholds.
REQ-038 The sequencer registers the grade_classifier outputs on entry to RESULT.

Verification
REQ-039 Grades 25,25,25,24 -> result_valid one cycle after the 4th grade; total=99, failed=1, passed=0, award=0; pass_count stays 0.
REQ-040 Grades 25,25,25,25 -> total=100, passed=1, award=0; then grades 50,50,50,50 -> total=200, passed=1, award=1; student_count=2, pass_count=2, award_count=1.
REQ-041 Grades 255 x4 -> total=1020, award=1, and no wrap.
REQ-042 Hold result_ready=0 for 3 cycles after result_valid -> outputs stable and grade_ready=0 throughout; counters change only on the handshake cycle.
REQ-043 Grades 200,200, then abort together with a valid grade, then 10,10,10,10 -> total=40, failed=1; student_count increments by 1 only.
REQ-044 Assert rst while in RESULT with result_valid=1 -> next cycle result_valid=0, grade_ready=1, and all counters=0.

Source files
------------

// File: rtl/exam_pkg.sv
// Shared definitions for the exam grade sequencer: widths, section count,
// default classification thresholds and the sequencer state encoding.
package exam_pkg;
    localparam int GRADE_W          = 8;
    localparam int TOTAL_W          = 10;
    localparam int CNT_W            = 8;
    localparam int NUM_SECTIONS     = 4;
    localparam int IDX_W            = 2;
    localparam int DEF_PASS_THRESH  = 100;
    localparam int DEF_AWARD_THRESH = 200;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;
endpackage

// File: rtl/exam_grade_sequencer_if.sv
// Bus bundle between a grade producer / result consumer and the sequencer.
//   grade_valid/grade_data/grade_ready : grade input handshake
//   abort                              : drop the student in progress
//   result_valid/result_ready          : result output handshake
//   total, failed, passed, award_scholarship : result fields
//   student_count, pass_count, award_count   : completed-student statistics
// master = producer/consumer side, slave = sequencer side.
interface exam_grade_sequencer_if;
    import exam_pkg::*;

    logic               grade_valid;
    logic [GRADE_W-1:0] grade_data;
    logic               grade_ready;
    logic               abort;
    logic               result_valid;
    logic               result_ready;
    logic [TOTAL_W-1:0] total;
    logic               failed;
    logic               passed;
    logic               award_scholarship;
    logic [CNT_W-1:0]   student_count;
    logic [CNT_W-1:0]   pass_count;
    logic [CNT_W-1:0]   award_count;

    modport master (
        output grade_valid, grade_data, abort, result_ready,
        input  grade_ready, result_valid, total, failed, passed,
               award_scholarship, student_count, pass_count, award_count
    );

    modport slave (
        input  grade_valid, grade_data, abort, result_ready,
        output grade_ready, result_valid, total, failed, passed,
               award_scholarship, student_count, pass_count, award_count
    );
endinterface

// File: rtl/grade_classifier.sv
// Purely combinational classification of a four-section total.
//   total  : summed grade (input)
//   failed : total below PASS_THRESH
//   passed : total at or above PASS_THRESH
//   award  : total at or above AWARD_THRESH (implies passed)
module grade_classifier
    import exam_pkg::*;
#(
    parameter int PASS_THRESH  = DEF_PASS_THRESH,
    parameter int AWARD_THRESH = DEF_AWARD_THRESH
) (
    input  logic [TOTAL_W-1:0] total,
    output logic               failed,
    output logic               passed,
    output logic               award
);
    always_comb begin
        passed = (total >= TOTAL_W'(PASS_THRESH));
        failed = !passed;
        award  = (total >= TOTAL_W'(AWARD_THRESH));
    end
endmodule

// File: rtl/exam_grade_sequencer.sv
// Collects four section grades per student, presents the registered total
// and its classification until the consumer takes it, and keeps wrapping
// counts of completed, passing and scholarship students.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of exam_grade_sequencer_if (grade in, result out)
module exam_grade_sequencer
    import exam_pkg::*;
#(
    parameter int PASS_THRESH  = DEF_PASS_THRESH,
    parameter int AWARD_THRESH = DEF_AWARD_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    exam_grade_sequencer_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SECTIONS - 1);

    state_t             state_q, state_d;
    logic [TOTAL_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               failed_q, failed_d;
    logic               passed_q, passed_d;
    logic               award_q, award_d;
    logic [CNT_W-1:0]   student_q, student_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   award_cnt_q, award_cnt_d;

    logic [TOTAL_W-1:0] sum;
    logic               cls_failed, cls_passed, cls_award;

    // 4 * 255 fits in TOTAL_W bits, so the running sum cannot overflow.
    assign sum = acc_q + TOTAL_W'(bus.grade_data);

    // Classify the sum including the grade being accepted, so the final
    // verdict can be captured on the same edge that enters RESULT.
    grade_classifier #(
        .PASS_THRESH  (PASS_THRESH),
        .AWARD_THRESH (AWARD_THRESH)
    ) u_classifier (
        .total  (sum),
        .failed (cls_failed),
        .passed (cls_passed),
        .award  (cls_award)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        failed_d    = failed_q;
        passed_d    = passed_q;
        award_d     = award_q;
        student_d   = student_q;
        pass_d      = pass_q;
        award_cnt_d = award_cnt_q;

        if (state_q == COLLECT) begin
            if (bus.abort) begin
                // Abort wins over a grade offered in the same cycle.
                acc_d = '0;
                idx_d = '0;
            end else if (bus.grade_valid) begin
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d  = RESULT;
                    failed_d = cls_failed;
                    passed_d = cls_passed;
                    award_d  = cls_award;
                end
            end
        end else begin
            // abort and grade_valid are ignored here; only the handshake exits.
            if (bus.result_ready) begin
                state_d     = COLLECT;
                acc_d       = '0;
                idx_d       = '0;
                failed_d    = 1'b0;
                passed_d    = 1'b0;
                award_d     = 1'b0;
                student_d   = student_q + CNT_W'(1);
                pass_d      = pass_q + CNT_W'(passed_q);
                award_cnt_d = award_cnt_q + CNT_W'(award_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            idx_q       <= '0;
            failed_q    <= 1'b0;
            passed_q    <= 1'b0;
            award_q     <= 1'b0;
            student_q   <= '0;
            pass_q      <= '0;
            award_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            failed_q    <= failed_d;
            passed_q    <= passed_d;
            award_q     <= award_d;
            student_q   <= student_d;
            pass_q      <= pass_d;
            award_cnt_q <= award_cnt_d;
        end
    end

    // The accumulator doubles as the total output: partial sum while
    // collecting, full sum held through RESULT.
    assign bus.grade_ready       = (state_q == COLLECT);
    assign bus.result_valid      = (state_q == RESULT);
    assign bus.total             = acc_q;
    assign bus.failed            = failed_q;
    assign bus.passed            = passed_q;
    assign bus.award_scholarship = award_q;
    assign bus.student_count     = student_q;
    assign bus.pass_count        = pass_q;
    assign bus.award_count       = award_cnt_q;
endmodule

// File: tb/tb_exam_grade_sequencer.sv
// Scoreboard bench for exam_grade_sequencer: the driver pushes the expected
// result of every completed student; a monitor compares on every cycle the
// DUT presents a result and pops on the handshake.
module tb_exam_grade_sequencer;
    localparam int P = 100;
    localparam int A = 200;

    typedef struct {
        int total;
        int failed;
        int passed;
        int award;
        int sc;
        int pc;
        int ac;
    } exp_t;

    logic clk;
    logic rst;
    exam_grade_sequencer_if bus ();

    exam_grade_sequencer #(
        .PASS_THRESH  (P),
        .AWARD_THRESH (A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   checks;
    int   errors;
    exp_t exp_q[$];
    int   m_sc, m_pc, m_ac;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Drive one cycle worth of inputs, then step just past the next edge.
    task automatic cyc(input int v, input int d, input int ab, input int rr, input int r);
        bus.grade_valid  = 1'(v);
        bus.grade_data   = 8'(d);
        bus.abort        = 1'(ab);
        bus.result_ready = 1'(rr);
        rst              = 1'(r);
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int sum);
        exp_t e;
        e.total  = sum;
        e.failed = (sum < P) ? 1 : 0;
        e.passed = (sum >= P) ? 1 : 0;
        e.award  = (sum >= A) ? 1 : 0;
        e.sc     = m_sc;
        e.pc     = m_pc;
        e.ac     = m_ac;
        exp_q.push_back(e);
    endtask

    // Result phase: hold with noise on grade/abort, then handshake and
    // account for the student in the model statistics.
    task automatic finish_student(input int sum, input int hold);
        push_exp(sum);
        for (int i = 0; i < hold; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1), 0, 0);
        cyc($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1), 1, 0);
        m_sc = (m_sc + 1) % 256;
        if (sum >= P) m_pc = (m_pc + 1) % 256;
        if (sum >= A) m_ac = (m_ac + 1) % 256;
    endtask

    task automatic student4(input int g0, input int g1, input int g2, input int g3, input int hold);
        cyc(1, g0, 0, 0, 0);
        cyc(1, g1, 0, 0, 0);
        cyc(1, g2, 0, 0, 0);
        cyc(1, g3, 0, 0, 0);
        finish_student(g0 + g1 + g2 + g3, hold);
    endtask

    // Monitor: samples mid-cycle, when inputs for the next edge are settled.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (bus.result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("res_total", int'(bus.total), exp_q[0].total);
                chk("res_failed", int'(bus.failed), exp_q[0].failed);
                chk("res_passed", int'(bus.passed), exp_q[0].passed);
                chk("res_award", int'(bus.award_scholarship), exp_q[0].award);
                chk("res_student_count", int'(bus.student_count), exp_q[0].sc);
                chk("res_pass_count", int'(bus.pass_count), exp_q[0].pc);
                chk("res_award_count", int'(bus.award_count), exp_q[0].ac);
                chk("res_grade_ready", int'(bus.grade_ready), 0);
                if (bus.result_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("col_grade_ready", int'(bus.grade_ready), 1);
            chk("col_class_bits",
                int'({bus.failed, bus.passed, bus.award_scholarship}), 0);
        end
    end

    initial begin
        int acc, n, g, r, gmax;
        checks = 0;
        errors = 0;
        m_sc = 0;
        m_pc = 0;
        m_ac = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("rst_grade_ready", int'(bus.grade_ready), 1);
        chk("rst_result_valid", int'(bus.result_valid), 0);
        chk("rst_total", int'(bus.total), 0);
        chk("rst_class_bits", int'({bus.failed, bus.passed, bus.award_scholarship}), 0);
        chk("rst_counts", int'({bus.student_count, bus.pass_count, bus.award_count}), 0);

        // Just below pass, exact pass, exact award.
        cyc(1, 25, 0, 0, 0);
        cyc(1, 25, 0, 0, 0);
        cyc(1, 25, 0, 0, 0);
        cyc(1, 24, 0, 0, 0);
        chk("lat_result_valid", int'(bus.result_valid), 1);
        finish_student(99, 0);
        student4(25, 25, 25, 25, 1);
        student4(50, 50, 50, 50, 3);
        chk("dir_student_count", int'(bus.student_count), 3);
        chk("dir_pass_count", int'(bus.pass_count), 2);
        chk("dir_award_count", int'(bus.award_count), 1);

        // Maximum grades, no wrap of the total.
        student4(255, 255, 255, 255, 2);

        // Partial sum visible, then abort with a simultaneous grade.
        cyc(1, 200, 0, 0, 0);
        cyc(1, 200, 0, 0, 0);
        chk("partial_total", int'(bus.total), 400);
        cyc(1, 77, 1, 0, 0);
        chk("abort_total", int'(bus.total), 0);
        student4(10, 10, 10, 10, 0);
        chk("abort_student_count", int'(bus.student_count), 5);

        // Reset while a result is pending.
        cyc(1, 100, 0, 0, 0);
        cyc(1, 100, 0, 0, 0);
        cyc(1, 100, 0, 0, 0);
        cyc(1, 100, 0, 0, 0);
        chk("pre_rst_result_valid", int'(bus.result_valid), 1);
        cyc(0, 0, 0, 0, 1);
        m_sc = 0;
        m_pc = 0;
        m_ac = 0;
        chk("rst_res_result_valid", int'(bus.result_valid), 0);
        chk("rst_res_grade_ready", int'(bus.grade_ready), 1);
        chk("rst_res_counts", int'({bus.student_count, bus.pass_count, bus.award_count}), 0);
        cyc(0, 0, 0, 0, 0);

        // Random students with idles and aborts; enough to wrap the counters.
        for (int s = 0; s < 300; s++) begin
            acc = 0;
            n = 0;
            r = $urandom_range(0, 2);
            gmax = (r == 0) ? 30 : ((r == 1) ? 60 : 255);
            while (n < 4) begin
                r = $urandom_range(0, 11);
                if (r == 0) begin
                    cyc($urandom_range(0, 1), $urandom_range(0, 255), 1, $urandom_range(0, 1), 0);
                    acc = 0;
                    n = 0;
                end else if (r == 1) begin
                    cyc(0, $urandom_range(0, 255), 0, $urandom_range(0, 1), 0);
                end else begin
                    g = $urandom_range(0, gmax);
                    cyc(1, g, 0, $urandom_range(0, 1), 0);
                    acc += g;
                    n++;
                end
            end
            finish_student(acc, $urandom_range(0, 3));
        end

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("end_student_count", int'(bus.student_count), m_sc);
        chk("end_pass_count", int'(bus.pass_count), m_pc);
        chk("end_award_count", int'(bus.award_count), m_ac);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
